gmii2fifo72: RTL and testbench

- Receive-side counterpart of the GMII transmit serializer.
- Samples GMII RX bytes and packs them little-endian into 72-bit FIFO words: 64 data bits plus 8 byte-valid flags, with byte i in din[8i+7:8i] and its flag in din[64+i].
- Every frame ends with a word that has at least one clear valid flag, so the transmit-side reader stops at a frame boundary.
- Sits between the GMII RX pins and the write port of a 72-bit async FIFO; wr_clk is driven from gmii_rx_clk.

---
 rtl/gmii2fifo72.sv | 168 ++++++++++++++++
 tb/tb_gmii2fifo72.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gmii2fifo72.sv
// gmii2fifo72: packs GMII receive bytes little-endian into 72-bit FIFO words
// (64 data bits + 8 byte-valid flags). Every frame is closed by a word with at
// least one clear flag so the reader on the far side stops on a frame boundary.
module gmii2fifo72 #(
  parameter int CNT_W = 16
) (
  input  logic             gmii_rx_clk,
  input  logic             sys_rst_n,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  input  logic [7:0]       gmii_rxd,
  input  logic             full,
  output logic [71:0]      din,
  output logic             wr_en,
  output logic             wr_clk,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, RECV, FLUSH, DROP} state_t;

  state_t      state, state_nx;
  logic [63:0] data_q, data_nx;
  logic [7:0]  flag_q, flag_nx;
  logic [2:0]  idx, idx_nx;
  logic        new_drop, new_drop_nx;
  logic        dv_gone, dv_gone_nx;
  logic        drop_now;
  logic [71:0] din_nx;
  logic        wr_nx;
  logic        ovf_inc;
  logic        dv_q;
  logic        err_seen;
  logic        err_end;
  logic [63:0] lane_data;
  logic [7:0]  lane_flag;

  assign wr_clk = gmii_rx_clk;

  // Shift register with the current byte merged into lane idx; lanes above idx are still zero
  assign lane_data = data_q | ({56'd0, gmii_rxd} << {idx, 3'b000});
  assign lane_flag = flag_q | (8'd1 << idx);

  // A frame ends on the first cycle rx_dv is low after being high
  assign err_end = dv_q & ~gmii_rx_dv & err_seen;

  // Next-state, shift register and write decisions; full is checked in the deciding cycle
  always_comb begin
    state_nx    = state;
    data_nx     = data_q;
    flag_nx     = flag_q;
    idx_nx      = idx;
    new_drop_nx = new_drop;
    dv_gone_nx  = dv_gone;
    din_nx      = din;
    wr_nx       = 1'b0;
    ovf_inc     = 1'b0;
    drop_now    = 1'b0;
    case (state)
      IDLE: begin
        if (gmii_rx_dv) begin
          data_nx  = {56'd0, gmii_rxd};
          flag_nx  = 8'h01;
          idx_nx   = 3'd1;
          state_nx = RECV;
        end
      end
      RECV: begin
        if (gmii_rx_dv) begin
          if (idx == 3'd7) begin
            if (!full) begin
              wr_nx  = 1'b1;
              din_nx = {8'hFF, lane_data};
            end else begin
              ovf_inc    = 1'b1;
              dv_gone_nx = 1'b0;
              state_nx   = DROP;
            end
            data_nx = 64'd0;
            flag_nx = 8'd0;
            idx_nx  = 3'd0;
          end else begin
            data_nx = lane_data;
            flag_nx = lane_flag;
            idx_nx  = idx + 3'd1;
          end
        end else if (!full) begin
          wr_nx    = 1'b1;
          din_nx   = {flag_q, data_q};
          data_nx  = 64'd0;
          flag_nx  = 8'd0;
          idx_nx   = 3'd0;
          state_nx = IDLE;
        end else begin
          new_drop_nx = 1'b0;
          state_nx    = FLUSH;
        end
      end
      FLUSH: begin
        drop_now = new_drop | gmii_rx_dv;
        if (gmii_rx_dv && !new_drop) ovf_inc = 1'b1;
        new_drop_nx = drop_now;
        if (!full) begin
          wr_nx       = 1'b1;
          din_nx      = {flag_q, data_q};
          data_nx     = 64'd0;
          flag_nx     = 8'd0;
          idx_nx      = 3'd0;
          new_drop_nx = 1'b0;
          dv_gone_nx  = 1'b0;
          state_nx    = drop_now ? DROP : IDLE;
        end
      end
      DROP: begin
        if (!gmii_rx_dv || dv_gone) begin
          dv_gone_nx = 1'b1;
          if (!full) begin
            wr_nx      = 1'b1;
            din_nx     = 72'd0;
            dv_gone_nx = 1'b0;
            state_nx   = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, shift register and registered FIFO write port
  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      data_q   <= 64'd0;
      flag_q   <= 8'd0;
      idx      <= 3'd0;
      new_drop <= 1'b0;
      dv_gone  <= 1'b0;
      din      <= 72'd0;
      wr_en    <= 1'b0;
    end else begin
      state    <= state_nx;
      data_q   <= data_nx;
      flag_q   <= flag_nx;
      idx      <= idx_nx;
      new_drop <= new_drop_nx;
      dv_gone  <= dv_gone_nx;
      din      <= din_nx;
      wr_en    <= wr_nx;
    end
  end

  // Per-frame error tracking and the two saturating counters
  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dv_q     <= 1'b0;
      err_seen <= 1'b0;
      ovf_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      dv_q <= gmii_rx_dv;
      if (gmii_rx_dv && gmii_rx_er) err_seen <= 1'b1;
      else if (!gmii_rx_dv)         err_seen <= 1'b0;
      if (ovf_inc && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + CNT_W'(1);
      if (err_end && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gmii2fifo72.sv
// Testbench for gmii2fifo72: directed frames, a frame-level packing model feeding
// an expected-word queue, and literal checks on the words actually written.
module tb_gmii2fifo72;

  logic        gmii_rx_clk;
  logic        sys_rst_n;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [7:0]  gmii_rxd;
  logic        full;
  logic [71:0] din;
  logic        wr_en;
  logic        wr_clk;
  logic [15:0] ovf_cnt;
  logic [15:0] err_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [71:0] exp_q[$];
  logic [71:0] wlog[$];
  int          exp_ovf = 0;
  int          exp_err = 0;
  logic        full_at_edge = 1'b0;

  gmii2fifo72 #(.CNT_W(16)) dut (
    .gmii_rx_clk (gmii_rx_clk),
    .sys_rst_n   (sys_rst_n),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rx_er  (gmii_rx_er),
    .gmii_rxd    (gmii_rxd),
    .full        (full),
    .din         (din),
    .wr_en       (wr_en),
    .wr_clk      (wr_clk),
    .ovf_cnt     (ovf_cnt),
    .err_cnt     (err_cnt)
  );

  // 100 MHz receive clock
  initial gmii_rx_clk = 1'b0;
  always #5 gmii_rx_clk = ~gmii_rx_clk;

  // full as seen by the DUT at each rising edge, i.e. when it decides to write
  always @(posedge gmii_rx_clk) full_at_edge <= full;

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Frame-level packing rule: 8 bytes per word little-endian, then a closing word
  // holding the remainder (all-zero when the length is a multiple of 8)
  task automatic modelFrame(input int n, input logic [7:0] start, input logic [7:0] step);
    logic [63:0] d;
    logic [7:0]  f;
    d = '0;
    f = '0;
    for (int i = 0; i < n; i++) begin
      d[8*(i%8) +: 8] = 8'(int'(start) + i * int'(step));
      f[i%8] = 1'b1;
      if (i % 8 == 7) begin
        exp_q.push_back({f, d});
        d = '0;
        f = '0;
      end
    end
    exp_q.push_back({f, d});
  endtask

  // Drives one frame byte by byte, then gap idle cycles; full is raised from
  // byte full_from on and held for full_hold idle cycles after the frame
  task automatic applyStimulus(input int n, input logic [7:0] start, input logic [7:0] step,
                               input int er_pos, input int full_from, input int full_hold,
                               input int gap, input bit use_model);
    if (use_model) modelFrame(n, start, step);
    if (er_pos >= 0 && er_pos < n) exp_err++;
    for (int i = 0; i < n; i++) begin
      @(posedge gmii_rx_clk);
      #1;
      gmii_rx_dv = 1'b1;
      gmii_rxd   = 8'(int'(start) + i * int'(step));
      gmii_rx_er = (i == er_pos);
      full       = (full_from >= 0) && (i >= full_from);
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge gmii_rx_clk);
      #1;
      gmii_rx_dv = 1'b0;
      gmii_rx_er = 1'b0;
      gmii_rxd   = 8'h00;
      full       = (full_from >= 0) && (g < full_hold);
    end
  endtask

  // Waits (bounded) for the expected words, then checks nothing is left and the counters
  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(posedge gmii_rx_clk);
      t++;
    end
    repeat (4) @(posedge gmii_rx_clk);
    #1;
    checkOutput({name, "_pending"}, 72'(exp_q.size()), 72'd0);
    checkOutput({name, "_ovf_cnt"}, 72'(ovf_cnt), 72'(exp_ovf));
    checkOutput({name, "_err_cnt"}, 72'(err_cnt), 72'(exp_err));
  endtask

  // Every FIFO write is checked against the model queue and against full
  always @(negedge gmii_rx_clk) begin
    if (sys_rst_n && wr_en) begin
      wlog.push_back(din);
      checkOutput("wr_while_full", {71'd0, full_at_edge}, 72'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_write: got %h, expected no write", din);
      end else begin
        checkOutput("write_word", din, exp_q.pop_front());
      end
    end
  end

  initial begin
    sys_rst_n  = 1'b0;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    gmii_rxd   = 8'h00;
    full       = 1'b0;
    repeat (3) @(posedge gmii_rx_clk);
    #1;
    checkOutput("reset_din", din, 72'd0);
    checkOutput("reset_wr_en", 72'(wr_en), 72'd0);
    checkOutput("reset_ovf_cnt", 72'(ovf_cnt), 72'd0);
    checkOutput("reset_err_cnt", 72'(err_cnt), 72'd0);
    checkOutput("wr_clk_high", 72'(wr_clk), 72'd1);
    sys_rst_n = 1'b1;
    @(negedge gmii_rx_clk);
    #1;
    checkOutput("wr_clk_low", 72'(wr_clk), 72'd0);

    $display("[TB] 8-byte frame");
    wlog.delete();
    applyStimulus(8, 8'h01, 8'h01, -1, -1, 0, 3, 1'b1);
    drain("frame8");
    checkOutput("frame8_count", 72'(wlog.size()), 72'd2);
    checkOutput("frame8_word0", wlog[0], 72'hFF_0807060504030201);
    checkOutput("frame8_term", wlog[1], 72'h00_0000000000000000);

    $display("[TB] 3-byte frame");
    wlog.delete();
    applyStimulus(3, 8'hAA, 8'h11, -1, -1, 0, 3, 1'b1);
    drain("frame3");
    checkOutput("frame3_count", 72'(wlog.size()), 72'd1);
    checkOutput("frame3_word", wlog[0], 72'h07_0000000000CCBBAA);

    $display("[TB] 64-byte frame, 1-cycle gap, 5-byte frame");
    wlog.delete();
    applyStimulus(64, 8'h00, 8'h01, -1, -1, 0, 1, 1'b1);
    applyStimulus(5, 8'h80, 8'h01, -1, -1, 0, 3, 1'b1);
    drain("b2b");
    checkOutput("b2b_count", 72'(wlog.size()), 72'd10);
    checkOutput("b2b_word7", wlog[7], 72'hFF_3F3E3D3C3B3A3938);
    checkOutput("b2b_term", wlog[8], 72'd0);
    checkOutput("b2b_frame2", wlog[9], 72'h1F_0000008483828180);

    $display("[TB] 20-byte frame with full during second word");
    wlog.delete();
    exp_q.push_back(72'hFF_4746454443424140);
    exp_q.push_back(72'd0);
    exp_ovf = 1;
    applyStimulus(20, 8'h40, 8'h01, -1, 12, 3, 6, 1'b0);
    drain("ovf");
    checkOutput("ovf_count", 72'(wlog.size()), 72'd2);

    $display("[TB] 10-byte frame with rx_er, then clean frame");
    wlog.delete();
    applyStimulus(10, 8'h10, 8'h01, 4, -1, 0, 3, 1'b1);
    drain("err");
    checkOutput("err_word0", wlog[0], 72'hFF_1716151413121110);
    checkOutput("err_word1", wlog[1], 72'h03_0000000000001918);
    checkOutput("err_cnt_lit", 72'(err_cnt), 72'd1);
    applyStimulus(4, 8'h30, 8'h01, -1, -1, 0, 3, 1'b1);
    drain("clean");
    checkOutput("clean_err_cnt_lit", 72'(err_cnt), 72'd1);

    $display("[TB] reset mid-frame");
    wlog.delete();
    for (int i = 0; i < 5; i++) begin
      @(posedge gmii_rx_clk);
      #1;
      gmii_rx_dv = 1'b1;
      gmii_rxd   = 8'(8'h50 + i);
    end
    @(posedge gmii_rx_clk);
    #1;
    sys_rst_n = 1'b0;
    exp_ovf   = 0;
    exp_err   = 0;
    #1;
    checkOutput("midrst_din", din, 72'd0);
    checkOutput("midrst_wr_en", 72'(wr_en), 72'd0);
    checkOutput("midrst_ovf_cnt", 72'(ovf_cnt), 72'd0);
    gmii_rx_dv = 1'b0;
    @(posedge gmii_rx_clk);
    #1;
    sys_rst_n = 1'b1;
    applyStimulus(3, 8'h21, 8'h01, -1, -1, 0, 3, 1'b1);
    drain("postrst");
    checkOutput("postrst_count", 72'(wlog.size()), 72'd1);
    checkOutput("postrst_word", wlog[0], 72'h07_0000000000232221);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
